key_conditioner: RTL and testbench

Upstream input stage for the run/stop counter path. The block synchronises a raw board pushbutton, debounces it, and classifies presses. It produces clean single-cycle press, release and long-press events plus a latched `run_en` level that toggles on each press. `run_en` drives the counter's `enable` input directly, replacing the raw `stop` switch.

---
 rtl/key_conditioner_pkg.sv | 17 +
 rtl/key_conditioner_if.sv | 36 +++
 rtl/key_conditioner_sync_2ff.sv | 28 ++
 rtl/key_conditioner.sv | 151 +++++++++++++++
 tb/tb_key_conditioner.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared types and default constants for the pushbutton conditioner.
//   key_state_t      : debounce FSM state encoding
//   KEY_DEBOUNCE_DEF : default debounce length (10 ms at 100 MHz)
//   KEY_LONG_DEF     : default long-press length (1 s at 100 MHz)
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_t;

    localparam int unsigned KEY_DEBOUNCE_DEF = 1_000_000;
    localparam int unsigned KEY_LONG_DEF     = 100_000_000;

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle between the raw pushbutton and the conditioned event consumers.
//   key         : raw asynchronous pushbutton level
//   key_level   : debounced pressed level (1 = pressed)
//   key_press   : one-cycle accepted-press pulse
//   key_release : one-cycle accepted-release pulse
//   key_long    : one-cycle long-press pulse, at most once per press
//   run_en      : run/stop level, toggles on every accepted press
// master = conditioner side, slave = board/consumer side.
interface key_conditioner_if;

    logic key;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;
    logic run_en;

    modport master (
        input  key,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output run_en
    );

    modport slave (
        output key,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  run_en
    );

endinterface

// File: rtl/key_conditioner_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit board input.
//   clk : destination clock
//   rst : asynchronous active-low reset, both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronised output (two cycles of latency)
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Plain shift pair; meta is the only flop allowed to go metastable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronise, debounce and classify a raw key into
// press / release / long-press pulses plus a run_en level toggled per press.
//   clk : single clock, rising edge
//   rst : asynchronous active-low reset
//   kif : key_conditioner_if.master (raw key in, registered events out)
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = KEY_DEBOUNCE_DEF,
    parameter int unsigned LONG_PRESS_CYCLES = KEY_LONG_DEF,
    parameter bit          KEY_ACTIVE_LOW    = 1'b1,
    parameter bit          RUN_INIT          = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    key_conditioner_if.master kif
);

    // Debounce counter tops out at DEBOUNCE_CYCLES-1, hold counter at LONG_PRESS_CYCLES.
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LP_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_MAX   = LP_W'(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST  = LP_W'(LONG_PRESS_CYCLES - 1);

    logic key_sync;
    logic s;

    key_state_t      state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [LP_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            long_done_q, long_done_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic            run_q, run_d;

    // Synchroniser idles at the released raw level so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (KEY_ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (kif.key),
        .q   (key_sync)
    );

    // Normalise to active-high pressed.
    assign s = key_sync ^ KEY_ACTIVE_LOW;

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            run_q       <= RUN_INIT;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            run_q       <= run_d;
        end
    end

    // Next-state, counters and next-output values.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        run_d       = run_q;

        case (state_q)
            IDLE: begin
                long_done_d = 1'b0;
                if (s) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            // The IDLE->PRESS_CHK cycle counts as the first stable sample, so
            // DEBOUNCE_CYCLES more pressed samples here complete the press.
            PRESS_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = HELD;
                    press_d    = 1'b1;
                    run_d      = ~run_q;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d  = RELEASE_CHK;
                    db_cnt_d = '0;
                end else begin
                    if (hold_cnt_q != LP_MAX) begin
                        hold_cnt_d = hold_cnt_q + LP_W'(1);
                    end
                    // Pulse on the edge the counter lands on LONG_PRESS_CYCLES.
                    if (hold_cnt_q == LP_LAST && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
            end
            // Hold counter is frozen while a release is being qualified.
            RELEASE_CHK: begin
                if (s) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_long    = long_q;
    assign kif.run_en      = run_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner with a sample-history
// reference model feeding an event scoreboard checked by a separate monitor.
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int LP = 20;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    key_conditioner_if kif ();

    key_conditioner #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP),
        .KEY_ACTIVE_LOW    (1'b1),
        .RUN_INIT          (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    int checks = 0;
    int errors = 0;

    int exp_cyc[$];
    int exp_kind[$];
    int n_seen[3];

    // Reference model state
    int cyc;
    bit m_sync1, m_sync2;
    bit m_level, m_run, m_prev_s, m_long_done;
    int m_run1, m_run0, m_hold;

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "key_press";
            K_RELEASE: return "key_release";
            default:   return "key_long";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync1     = 1'b1;
        m_sync2     = 1'b1;
        m_level     = 1'b0;
        m_run       = 1'b1;
        m_prev_s    = 1'b0;
        m_long_done = 1'b0;
        m_run1      = 0;
        m_run0      = 0;
        m_hold      = 0;
        exp_cyc.delete();
        exp_kind.delete();
    endtask

    task automatic push(input int k);
        exp_cyc.push_back(cyc);
        exp_kind.push_back(k);
    endtask

    // Reference model: events follow from run lengths of the pressed level as
    // seen two cycles after the raw key is sampled.
    initial begin
        bit s;
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                cyc++;
                s = (m_sync2 == 1'b0);
                m_run1 = s ? m_run1 + 1 : 0;
                m_run0 = s ? 0 : m_run0 + 1;
                if (!m_level && m_run1 == DB + 1) begin
                    m_level     = 1'b1;
                    m_run       = ~m_run;
                    m_hold      = 0;
                    m_long_done = 1'b0;
                    push(K_PRESS);
                end else if (m_level && m_run0 == DB + 1) begin
                    m_level = 1'b0;
                    push(K_RELEASE);
                end else if (m_level && s && m_prev_s) begin
                    if (m_hold < LP) m_hold++;
                    if (m_hold == LP && !m_long_done) begin
                        m_long_done = 1'b1;
                        push(K_LONG);
                    end
                end
                m_prev_s = s;
                m_sync2  = m_sync1;
                m_sync1  = kif.key;
            end
        end
    end

    // Monitor: compares levels every cycle and pops expected events on pulses.
    initial begin
        bit ev[3];
        forever begin
            @(negedge clk);
            check("key_level", int'(kif.key_level), int'(m_level));
            check("run_en", int'(kif.run_en), int'(m_run));
            check("press_release_exclusive", int'(kif.key_press & kif.key_release), 0);
            ev[K_PRESS]   = kif.key_press;
            ev[K_RELEASE] = kif.key_release;
            ev[K_LONG]    = kif.key_long;
            for (int k = 0; k < 3; k++) begin
                if (ev[k]) begin
                    n_seen[k]++;
                    check({kname(k), "_expected"}, int'(exp_kind.size() > 0), 1);
                    if (exp_kind.size() > 0) begin
                        check({kname(k), "_kind"}, k, exp_kind[0]);
                        check({kname(k), "_cycle"}, cyc, exp_cyc[0]);
                        void'(exp_kind.pop_front());
                        void'(exp_cyc.pop_front());
                    end
                end
            end
            while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
                check({"missed_", kname(exp_kind[0])}, cyc, exp_cyc[0]);
                void'(exp_kind.pop_front());
                void'(exp_cyc.pop_front());
            end
        end
    end

    task automatic hold(input logic v, input int n);
        kif.key = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input int n);
        #2 rst = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int p0, r0, l0;
        kif.key = 1'b1;

        // Reset with key released, then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        hold(1'b1, 5);
        check("idle_run_en", int'(kif.run_en), 1);
        check("idle_level", int'(kif.key_level), 0);

        // Clean press, then release
        p0 = n_seen[K_PRESS];
        hold(1'b0, 15);
        check("clean_press_count", n_seen[K_PRESS] - p0, 1);
        check("clean_press_run_en", int'(kif.run_en), 0);
        hold(1'b1, 12);

        // Bouncing input never qualifies
        p0 = n_seen[K_PRESS]; r0 = n_seen[K_RELEASE]; l0 = n_seen[K_LONG];
        for (int i = 0; i < 6; i++) begin
            hold(1'b0, 2);
            hold(1'b1, 2);
        end
        hold(1'b1, 10);
        check("bounce_press_count", n_seen[K_PRESS] - p0, 0);
        check("bounce_release_count", n_seen[K_RELEASE] - r0, 0);
        check("bounce_long_count", n_seen[K_LONG] - l0, 0);

        // Long press, exactly one key_long
        p0 = n_seen[K_PRESS]; l0 = n_seen[K_LONG];
        hold(1'b0, 40);
        check("long_press_count", n_seen[K_PRESS] - p0, 1);
        check("long_long_count", n_seen[K_LONG] - l0, 1);
        hold(1'b1, 12);

        // Second press with a one-cycle release glitch while held
        p0 = n_seen[K_PRESS]; r0 = n_seen[K_RELEASE];
        hold(1'b0, 10);
        hold(1'b1, 1);
        hold(1'b0, 8);
        check("glitch_press_count", n_seen[K_PRESS] - p0, 1);
        check("glitch_release_count", n_seen[K_RELEASE] - r0, 0);
        hold(1'b1, 12);
        check("clean_release_count", n_seen[K_RELEASE] - r0, 1);

        // Reset while qualifying a press, key kept pressed
        p0 = n_seen[K_PRESS];
        kif.key = 1'b0;
        repeat (3) @(posedge clk);
        reset_pulse(2);
        check("reset_run_en", int'(kif.run_en), 1);
        hold(1'b0, 15);
        check("post_reset_press_count", n_seen[K_PRESS] - p0, 1);
        hold(1'b1, 12);

        // Random segments
        for (int i = 0; i < 60; i++) begin
            logic v;
            int n;
            v = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 30))
                                            : int'($urandom_range(1, 7));
            hold(v, n);
            if ($urandom_range(0, 19) == 0) reset_pulse(2);
        end

        hold(1'b1, 15);
        check("scoreboard_drained", exp_cyc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
